// File: rtl/tlb_op_ctrl_pkg.sv
// Types shared by the TLB instruction controller and its random-index generator.
//   tlb_index_t    : TLB index, wide enough for the largest supported TLB (64 entries)
//   tlb_entry_t    : one TLB entry (VPN2/ASID/G plus even/odd page descriptors)
//   tlb_op_t       : TLB instruction op codes
//   tlb_op_state_t : controller FSM states
package tlb_op_ctrl_pkg;

  localparam int TLB_INDEX_W = 6;

  typedef logic [TLB_INDEX_W-1:0] tlb_index_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    TLB_OP_TLBP  = 2'b00,
    TLB_OP_TLBR  = 2'b01,
    TLB_OP_TLBWI = 2'b10,
    TLB_OP_TLBWR = 2'b11
  } tlb_op_t;

  typedef enum logic [1:0] {
    TLB_ST_IDLE = 2'd0,
    TLB_ST_EXEC = 2'd1,
    TLB_ST_DONE = 2'd2
  } tlb_op_state_t;

  // Both write ops have the upper op-code bit set.
  function automatic logic tlb_op_is_write(tlb_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// Pipeline-side handshake of the TLB instruction controller.
//   op_valid/op_code/flush : request from the pipeline
//   op_ready/stall         : controller can accept / pipeline hold request
//   done/done_op           : one-cycle completion pulse and its op code
// master = pipeline, slave = controller.
interface tlb_op_ctrl_if;
  import tlb_op_ctrl_pkg::*;

  logic       op_valid;
  logic [1:0] op_code;
  logic       flush;
  logic       op_ready;
  logic       stall;
  logic       done;
  logic [1:0] done_op;

  modport master (
    output op_valid, op_code, flush,
    input  op_ready, stall, done, done_op
  );

  modport slave (
    input  op_valid, op_code, flush,
    output op_ready, stall, done, done_op
  );

endinterface

// File: rtl/tlb_op_ctrl_random_gen.sv
// CP0 Random generator for TLBWR.
// Ports: clk, resetn (async active-low), wired (CP0 Wired), random (IW-bit index).
// Default build: down-counter over [wired, TLB_ENTRIES-1], reloading the top
// value once it reaches (or falls below) wired, or when wired covers the
// whole TLB.
// With TLB_OP_RANDOM_LFSR_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed A5),
// low IW bits used as the candidate, clamped to the top entry below wired.
module tlb_random_gen #(
  parameter int TLB_ENTRIES = 16
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [31:0]                    wired,
  output logic [$clog2(TLB_ENTRIES)-1:0] random
);
  localparam int IW = $clog2(TLB_ENTRIES);
  localparam logic [IW-1:0] TOP = IW'(TLB_ENTRIES - 1);

  logic [IW-1:0] random_q;

`ifdef TLB_OP_RANDOM_LFSR_EN
  logic [7:0]    lfsr_q;
  logic [IW-1:0] cand;

  assign cand = lfsr_q[IW-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q   <= 8'hA5;
      random_q <= TOP;
    end else begin
      lfsr_q   <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      random_q <= (32'(cand) < wired) ? TOP : cand;
    end
  end
`else
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      random_q <= TOP;
    end else if ((wired >= 32'(TLB_ENTRIES)) || (32'(random_q) <= wired)) begin
      // also covers Wired having been raised above the current value
      random_q <= TOP;
    end else begin
      random_q <= random_q - IW'(1);
    end
  end
`endif

  assign random = random_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB instruction controller (TLBP / TLBR / TLBWI / TLBWR).
// Ports:
//   clk, resetn         : clock, async active-low reset
//   op_if (slave)       : pipeline handshake (op_valid/op_code/flush in,
//                         op_ready/stall/done/done_op out)
//   cp0_index/wired/entry_hi/wentry : CP0 inputs
//   tlbrw_index/we/wdata, tlbrw_rdata, tlbp_entry_hi, tlbp_index : MMU TLB ports
//   rdata, probe_index  : results captured by TLBR / TLBP
//   random              : CP0 Random, zero-extended
// Optional macro TLB_OP_RANDOM_LFSR_EN selects the LFSR random source.
//
// state | meaning
// IDLE  | ready for a request
// EXEC  | TLB ports driven for one cycle; results captured at its end
// DONE  | completion pulse
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter int TLB_ENTRIES = 16
) (
  input  logic          clk,
  input  logic          resetn,
  tlb_op_ctrl_if.slave  op_if,
  input  logic [31:0]   cp0_index,
  input  logic [31:0]   cp0_wired,
  input  logic [31:0]   cp0_entry_hi,
  input  tlb_entry_t    cp0_wentry,
  output tlb_index_t    tlbrw_index,
  output logic          tlbrw_we,
  output tlb_entry_t    tlbrw_wdata,
  input  tlb_entry_t    tlbrw_rdata,
  output logic [31:0]   tlbp_entry_hi,
  input  logic [31:0]   tlbp_index,
  output tlb_entry_t    rdata,
  output logic [31:0]   probe_index,
  output logic [31:0]   random
);
  localparam int IW = $clog2(TLB_ENTRIES);

  tlb_op_state_t state_q, state_d;
  tlb_op_t       op_q;
  tlb_op_t       op_in;
  logic [IW-1:0] idx_q;
  logic [31:0]   ehi_q;
  logic [IW-1:0] random_idx;
  logic          accept;
  logic          unused_index_bits;

  assign op_in             = tlb_op_t'(op_if.op_code);
  assign accept            = (state_q == TLB_ST_IDLE) & op_if.op_valid & ~op_if.flush;
  assign unused_index_bits = ^cp0_index[31:IW];

  tlb_random_gen #(.TLB_ENTRIES(TLB_ENTRIES)) u_random_gen (
    .clk    (clk),
    .resetn (resetn),
    .wired  (cp0_wired),
    .random (random_idx)
  );

  assign random      = 32'(random_idx);
  assign tlbrw_wdata = cp0_wentry;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= TLB_ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLB_ST_IDLE: if (accept) state_d = TLB_ST_EXEC;
      TLB_ST_EXEC: state_d = op_if.flush ? TLB_ST_IDLE : TLB_ST_DONE;
      TLB_ST_DONE: state_d = TLB_ST_IDLE;
      default:     state_d = TLB_ST_IDLE;
    endcase
  end

  always_comb begin
    op_if.op_ready = 1'b0;
    op_if.stall    = 1'b0;
    op_if.done     = 1'b0;
    op_if.done_op  = 2'b00;
    tlbrw_we       = 1'b0;
    tlbrw_index    = '0;
    tlbp_entry_hi  = '0;
    case (state_q)
      TLB_ST_IDLE: begin
        op_if.op_ready = 1'b1;
        op_if.stall    = op_if.op_valid & ~op_if.flush;
      end
      TLB_ST_EXEC: begin
        op_if.stall = 1'b1;
        // a write still goes out if flush arrives this cycle
        tlbrw_we    = tlb_op_is_write(op_q);
        if (op_q == TLB_OP_TLBP) tlbp_entry_hi = ehi_q;
        else                     tlbrw_index   = tlb_index_t'(idx_q);
      end
      TLB_ST_DONE: begin
        op_if.done    = ~op_if.flush;
        op_if.done_op = op_if.flush ? 2'b00 : op_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q        <= TLB_OP_TLBP;
      idx_q       <= '0;
      ehi_q       <= '0;
      rdata       <= '0;
      probe_index <= '0;
    end else begin
      if (accept) begin
        op_q  <= op_in;
        // TLBWR uses the Random value seen in the accept cycle
        idx_q <= (op_in == TLB_OP_TLBWR) ? random_idx : cp0_index[IW-1:0];
        ehi_q <= cp0_entry_hi;
      end
      if ((state_q == TLB_ST_EXEC) && !op_if.flush) begin
        if (op_q == TLB_OP_TLBR) rdata       <= tlbrw_rdata;
        if (op_q == TLB_OP_TLBP) probe_index <= tlbp_index;
      end
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
module tb_tlb_op_ctrl;
  import tlb_op_ctrl_pkg::*;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] cp0_index, cp0_wired, cp0_entry_hi;
  tlb_entry_t  cp0_wentry;
  tlb_index_t  tlbrw_index;
  logic        tlbrw_we;
  tlb_entry_t  tlbrw_wdata, tlbrw_rdata;
  logic [31:0] tlbp_entry_hi, tlbp_index;
  tlb_entry_t  rdata;
  logic [31:0] probe_index, random;

  always #5 clk = ~clk;

  tlb_op_ctrl_if op_if ();

  tlb_op_ctrl #(.TLB_ENTRIES(N)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .op_if        (op_if),
    .cp0_index    (cp0_index),
    .cp0_wired    (cp0_wired),
    .cp0_entry_hi (cp0_entry_hi),
    .cp0_wentry   (cp0_wentry),
    .tlbrw_index  (tlbrw_index),
    .tlbrw_we     (tlbrw_we),
    .tlbrw_wdata  (tlbrw_wdata),
    .tlbrw_rdata  (tlbrw_rdata),
    .tlbp_entry_hi(tlbp_entry_hi),
    .tlbp_index   (tlbp_index),
    .rdata        (rdata),
    .probe_index  (probe_index),
    .random       (random)
  );

  int tests = 0;
  int fails = 0;

  function automatic tlb_entry_t mk_entry(int i);
    tlb_entry_t e;
    e.vpn2 = 19'h100 + 19'(i);
    e.asid = 8'(i);
    e.g    = 1'b0;
    e.pfn0 = 20'h01000 + 20'(i);
    e.c0   = 3'd3;
    e.d0   = 1'b1;
    e.v0   = 1'b1;
    e.pfn1 = 20'h02000 + 20'(i);
    e.c1   = 3'd3;
    e.d1   = 1'b0;
    e.v1   = 1'b1;
    return e;
  endfunction

  task automatic chk1(string name, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chke(string name, tlb_entry_t act, tlb_entry_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // MMU TLB environment: writes land mid-cycle while tlbrw_we is high
  tlb_entry_t env_mem [N];
  initial begin
    for (int i = 0; i < N; i++) env_mem[i] = mk_entry(i);
    forever begin
      @(negedge clk);
      if (tlbrw_we) env_mem[tlbrw_index[3:0]] = tlbrw_wdata;
    end
  end

  always_comb begin
    tlbrw_rdata = env_mem[tlbrw_index[3:0]];
    tlbp_index  = 32'h8000_0000;
    for (int i = 0; i < N; i++)
      if (env_mem[i].vpn2 == tlbp_entry_hi[31:13]) tlbp_index = 32'(i);
  end

  // Behavioural model: age = cycles since acceptance (-1 when no op in flight)
  int          age;
  logic [1:0]  m_op;
  logic [3:0]  m_idx;
  logic [31:0] m_ehi;
  tlb_entry_t  m_rdata;
  logic [31:0] m_probe;
  int unsigned m_random;
  tlb_entry_t  m_mem [N];

  function automatic logic [31:0] model_probe(logic [31:0] ehi);
    logic [31:0] r = 32'h8000_0000;
    for (int i = 0; i < N; i++)
      if (m_mem[i].vpn2 == ehi[31:13]) r = 32'(i);
    return r;
  endfunction

  task automatic model_reset();
    age      = -1;
    m_op     = 2'b00;
    m_idx    = 4'd0;
    m_ehi    = 32'd0;
    m_rdata  = '0;
    m_probe  = 32'd0;
    m_random = N - 1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_mem[i] = mk_entry(i);
    model_reset();
    forever begin
      @(negedge clk);
      if (!resetn) model_reset();
      chk1("m_op_ready", op_if.op_ready, age < 0);
      chk1("m_stall", op_if.stall,
           (age < 0) ? (op_if.op_valid & ~op_if.flush) : (age == 0));
      chk1("m_done", op_if.done, (age == 1) && !op_if.flush);
      if ((age == 1) && !op_if.flush) chk32("m_done_op", 32'(op_if.done_op), 32'(m_op));
      chk1("m_we", tlbrw_we, (age == 0) && (m_op >= 2'd2));
      if (age != 0) chk32("m_idx_idle", 32'(tlbrw_index), 32'd0);
      else if (m_op != 2'd0) chk32("m_idx_exec", 32'(tlbrw_index), 32'(m_idx));
      if (age != 0) chk32("m_ehi_idle", tlbp_entry_hi, 32'd0);
      else if (m_op == 2'd0) chk32("m_ehi_exec", tlbp_entry_hi, m_ehi);
      chke("m_rdata", rdata, m_rdata);
      chk32("m_probe", probe_index, m_probe);
      chk32("m_random", random, m_random);
      if (resetn) begin
        if (age < 0) begin
          if (op_if.op_valid && !op_if.flush) begin
            age   = 0;
            m_op  = op_if.op_code;
            m_idx = (op_if.op_code == 2'd3) ? 4'(m_random) : cp0_index[3:0];
            m_ehi = cp0_entry_hi;
          end
        end else if (age == 0) begin
          if (m_op >= 2'd2) m_mem[m_idx] = cp0_wentry;
          if (op_if.flush) age = -1;
          else begin
            if (m_op == 2'd1) m_rdata = m_mem[m_idx];
            if (m_op == 2'd0) m_probe = model_probe(m_ehi);
            age = 1;
          end
        end else begin
          age = -1;
        end
        if ((cp0_wired >= N) || (m_random <= cp0_wired)) m_random = N - 1;
        else m_random = m_random - 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  tlb_entry_t w1, w2;
  logic       found;

  initial begin
    w1 = mk_entry(0);
    w1.vpn2 = 19'h0ABCD;
    w1.pfn0 = 20'hCAFE5;
    w2 = mk_entry(0);
    w2.vpn2 = 19'h0BEEF;
    resetn = 1'b0;
    op_if.op_valid = 1'b0;
    op_if.op_code  = 2'd0;
    op_if.flush    = 1'b0;
    cp0_index = 32'd0;
    cp0_wired = 32'd0;
    cp0_entry_hi = 32'd0;
    cp0_wentry = w1;
    repeat (3) step();
    #1;
    chke("rst_rdata", rdata, '0);
    chk32("rst_probe", probe_index, 32'd0);
    chk32("rst_random", random, 32'd15);
    chk1("rst_ready", op_if.op_ready, 1'b1);
    chk1("rst_done", op_if.done, 1'b0);
    chk1("rst_we", tlbrw_we, 1'b0);
    step();
    resetn = 1'b1;

    // TLBWI index 5
    cp0_index = 32'd5;
    op_if.op_code = 2'd2;
    op_if.op_valid = 1'b1;
    #1;
    chk1("wi_T_stall", op_if.stall, 1'b1);
    step();
    op_if.op_valid = 1'b0;
    #1;
    chk1("wi_T1_we", tlbrw_we, 1'b1);
    chk32("wi_T1_idx", 32'(tlbrw_index), 32'd5);
    step();
    #1;
    chk1("wi_T2_done", op_if.done, 1'b1);
    chk32("wi_T2_done_op", 32'(op_if.done_op), 32'd2);
    chk1("wi_T2_we", tlbrw_we, 1'b0);
    step();
    #1;
    chk1("wi_T3_ready", op_if.op_ready, 1'b1);

    // TLBR index 5 reads back the written entry
    op_if.op_code = 2'd1;
    op_if.op_valid = 1'b1;
    step();
    op_if.op_valid = 1'b0;
    step();
    #1;
    chke("r5_rdata", rdata, w1);
    step();

    // TLBR index 3
    cp0_index = 32'd3;
    op_if.op_valid = 1'b1;
    #1;
    chk1("r3_T_stall", op_if.stall, 1'b1);
    step();
    op_if.op_valid = 1'b0;
    #1;
    chk1("r3_T1_stall", op_if.stall, 1'b1);
    step();
    #1;
    chk1("r3_T2_stall", op_if.stall, 1'b0);
    chke("r3_T2_rdata", rdata, mk_entry(3));
    chk32("r3_T2_done_op", 32'(op_if.done_op), 32'd1);
    step();

    // TLBP miss, then hit on entry 7
    cp0_entry_hi = {19'h7FFFF, 13'h0};
    op_if.op_code = 2'd0;
    op_if.op_valid = 1'b1;
    step();
    op_if.op_valid = 1'b0;
    #1;
    chk32("pm_ehi", tlbp_entry_hi, {19'h7FFFF, 13'h0});
    step();
    #1;
    chk1("pm_bit31", probe_index[31], 1'b1);
    step();
    cp0_entry_hi = {19'h107, 5'd0, 8'd7};
    op_if.op_valid = 1'b1;
    step();
    op_if.op_valid = 1'b0;
    step();
    #1;
    chk32("ph_index", probe_index, 32'd7);
    step();

    // flush during EXEC of TLBR index 9
    cp0_index = 32'd9;
    op_if.op_code = 2'd1;
    op_if.op_valid = 1'b1;
    step();
    op_if.op_valid = 1'b0;
    op_if.flush = 1'b1;
    #1;
    chk1("fe_T1_done", op_if.done, 1'b0);
    step();
    op_if.flush = 1'b0;
    #1;
    chk1("fe_T2_ready", op_if.op_ready, 1'b1);
    chk1("fe_T2_done", op_if.done, 1'b0);
    chke("fe_rdata", rdata, mk_entry(3));

    // op_valid together with flush in IDLE is ignored
    op_if.op_valid = 1'b1;
    op_if.flush = 1'b1;
    #1;
    chk1("fi_stall", op_if.stall, 1'b0);
    step();
    op_if.op_valid = 1'b0;
    op_if.flush = 1'b0;
    #1;
    chk1("fi_ready", op_if.op_ready, 1'b1);
    chk1("fi_we", tlbrw_we, 1'b0);

    // flush in DONE suppresses the pulse
    cp0_index = 32'd3;
    op_if.op_valid = 1'b1;
    step();
    op_if.op_valid = 1'b0;
    step();
    op_if.flush = 1'b1;
    #1;
    chk1("fd_done", op_if.done, 1'b0);
    step();
    op_if.flush = 1'b0;
    #1;
    chk1("fd_ready", op_if.op_ready, 1'b1);

    // TLBWR at the current random index
    cp0_wentry = w2;
    op_if.op_code = 2'd3;
    op_if.op_valid = 1'b1;
    step();
    op_if.op_valid = 1'b0;
    #1;
    chk1("wr_we", tlbrw_we, 1'b1);
    step();
    step();

    // random sequence with Wired = 4
    cp0_wired = 32'd4;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      #1;
      if (random == 32'd15) found = 1'b1;
    end
    chk1("rand_sync15", found, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      step();
      #1;
      chk32("rand_seq", random, (k <= 11) ? 32'(15 - k) : 32'd15);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      #1;
      if (random == 32'd6) found = 1'b1;
    end
    chk1("rand_sync6", found, 1'b1);
    cp0_wired = 32'd10;
    step();
    #1;
    chk32("rand_wired_up", random, 32'd15);

    // reset during EXEC of TLBWR
    cp0_wired = 32'd0;
    op_if.op_code = 2'd3;
    op_if.op_valid = 1'b1;
    step();
    op_if.op_valid = 1'b0;
    #1;
    chk1("rs_exec_we", tlbrw_we, 1'b1);
    resetn = 1'b0;
    #1;
    chk32("rs_random", random, 32'd15);
    chk1("rs_ready", op_if.op_ready, 1'b1);
    chk1("rs_we", tlbrw_we, 1'b0);
    chk1("rs_done", op_if.done, 1'b0);
    step();
    resetn = 1'b1;
    step();
    #1;
    chk1("rs_done_after", op_if.done, 1'b0);
    step();
    #1;
    chk1("rs_done_after2", op_if.done, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tlb_op_ctrl.md
TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 16, the number of TLB entries (power of two, 2..64); IW = log2(TLB_ENTRIES).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port op_valid  in  1  TLB instruction request from the pipeline.
REQ-005 SHALL have port op_code  in  2  operation code: 00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR.
REQ-006 SHALL have port op_ready  out  1  the controller can accept a request.
REQ-007 SHALL have port flush  in  1  pipeline flush; aborts the pending response.
REQ-008 SHALL have port cp0_index  in  32  the CP0 Index register.
REQ-009 SHALL have port cp0_wired  in  32  the CP0 Wired register.
REQ-010 SHALL have port cp0_entry_hi  in  32  the CP0 EntryHi register.
REQ-011 SHALL have port cp0_wentry  in  tlb_entry_t  the entry to write, assembled from CP0.
REQ-012 SHALL have ports tlbrw_index out tlb_index_t, tlbrw_we out 1, tlbrw_wdata out tlb_entry_t, tlbrw_rdata in tlb_entry_t, tlbp_entry_hi out 32, tlbp_index in 32; these drive the MMU TLB ports.
REQ-013 SHALL have port done  out  1  one-cycle completion pulse.
REQ-014 SHALL have port done_op  out  2  op_code of the completed operation.
REQ-015 SHALL have port rdata  out  tlb_entry_t  the entry captured by TLBR.
REQ-016 SHALL have port probe_index  out  32  the result captured by TLBP.
REQ-017 SHALL have port random  out  32  the CP0 Random value; zero-extended IW bits.
REQ-018 SHALL have port stall  out  1  pipeline hold request.

Function
REQ-019 SHALL implement the states IDLE, EXEC and DONE; op_ready = (state==IDLE).
REQ-020 SHALL accept a request in cycle T when op_valid & op_ready & ~flush, latching op_code, the write index and cp0_entry_hi, and moving to EXEC.
REQ-021 EXEC (T+1) SHALL drive the TLB ports as follows:
- TLBP: tlbp_entry_hi = latched EntryHi.
- TLBR: tlbrw_index = cp0_index[IW-1:0].
- TLBWI: tlbrw_we = 1 with tlbrw_index = cp0_index[IW-1:0].
- TLBWR: tlbrw_we = 1 with tlbrw_index = random latched at T.
- tlbrw_wdata = cp0_wentry.
REQ-022 tlbrw_we SHALL be 1 only in EXEC for write ops: exactly one cycle per write.
REQ-023 At the end of EXEC the block SHALL capture tlbrw_rdata into rdata (TLBR only) and tlbp_index into probe_index (TLBP only); otherwise both hold their values.
REQ-024 DONE (T+2) SHALL assert done=1 with done_op; the next state is IDLE, so op_ready=1 at T+3; latency from accept to done is 2 cycles.
REQ-025 stall SHALL = (state==IDLE & op_valid & ~flush) | (state==EXEC); stall is 0 in DONE.
REQ-026 flush in EXEC SHALL send the FSM to IDLE with no done pulse; a write already driven in EXEC completes, and rdata/probe_index are not updated.
REQ-027 flush in DONE SHALL suppress done; the next state is IDLE.
REQ-028 Random counter: range [wired, TLB_ENTRIES-1].
- Decrements by one every cycle.
- From wired (or any value ≤ wired) it reloads TLB_ENTRIES-1.
- When cp0_wired ≥ TLB_ENTRIES it holds TLB_ENTRIES-1.
REQ-029 When random < cp0_wired (Wired was just raised), random SHALL load TLB_ENTRIES-1 on the next cycle.
REQ-030 tlbrw_index and tlbp_entry_hi SHALL be 0 outside EXEC.

Reset
REQ-031 While resetn=0 the block SHALL hold state=IDLE, done=0, done_op=0, rdata=0, probe_index=0, tlbrw_we=0, random=TLB_ENTRIES-1.
REQ-032 Reset asserted mid-operation SHALL abort immediately; a write in flight is dropped if reset arrives before the EXEC clock edge.

Configuration
REQ-033 With macro TLB_OP_RANDOM_LFSR_EN defined, the random index SHALL come from an 8-bit LFSR:
- Polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5, stepped every cycle.
- Candidate = lfsr[IW-1:0]; if candidate < wired, use TLB_ENTRIES-1.
REQ-034 Without the macro, the decrementing counter of REQ-028/029 SHALL be used.

Structure
REQ-035 The shared cpu package SHALL add tlb_op_t (2-bit enum of op codes) and tlb_op_state_t; tlb_index_t and tlb_entry_t are reused from it.
REQ-036 SHALL contain one sub-module, tlb_random_gen, which holds the counter/LFSR and the wired clamp.

Verification
REQ-037 TLBWI with cp0_index=5 accepted at T -> tlbrw_we=1 and tlbrw_index=5 only at T+1; done=1, done_op=2 at T+2; op_ready=1 at T+3.
REQ-038 TLBR with index 3, TLB entry 3 preloaded -> rdata equals entry 3 at T+2; stall=1 at T and T+1, and 0 at T+2.
REQ-039 TLBP where EntryHi misses -> probe_index bit31=1 at T+2; a hit on entry 7 -> probe_index=7.
REQ-040 wired=4, N=16, counter mode -> random cycles 15..4 then 15; wired raised to 10 while random=6 -> 15 next cycle.
REQ-041 TLBR with flush at T+1 -> no done pulse, rdata unchanged, op_ready=1 at T+2; op_valid together with flush in IDLE -> not accepted.
REQ-042 resetn deasserted during EXEC of a TLBWR -> no done pulse, random=15, state=IDLE.
